// File: rtl/mpmc12_mask_gen.sv
// Per-beat DDR write data-mask generator: turns one explicit byte-enable or byte-range request
// into a sequence of per-beat masks (1 = byte not written), advanced by the PHY beat strobe.
module mpmc12_mask_gen #(
  parameter  int DATA_BYTES = 32,
  parameter  int MAX_BEATS  = 8,
  localparam int OFSW       = $clog2(DATA_BYTES),
  localparam int LENW       = $clog2(DATA_BYTES * MAX_BEATS) + 1
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_rmw,
  input  logic [DATA_BYTES-1:0] req_wmask,
  input  logic [OFSW-1:0]       req_offset,
  input  logic [LENW-1:0]       req_len,
  input  logic                  beat_adv,
  output logic [DATA_BYTES-1:0] mask,
  output logic                  mask_valid,
  output logic                  mask_last,
  output logic                  busy,
  output logic                  err
);

  localparam int BCW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int SUMW = LENW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_LOAD  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t                state_q;
  logic                  we_q;
  logic                  rmw_q;
  logic [DATA_BYTES-1:0] wmask_q;
  logic [OFSW-1:0]       offset_q;
  logic [LENW-1:0]       len_q;
  logic [BCW-1:0]        last_q;
  logic [BCW-1:0]        beat_q;
  logic [DATA_BYTES-1:0] mask2_q;
  logic [DATA_BYTES-1:0] mask_q;
  logic                  mask_valid_q;
  logic                  mask_last_q;
  logic                  err_q;

  logic [BCW-1:0]        beat_d;
  logic [DATA_BYTES-1:0] mask_nxt_d;

  // Global byte index of (beat b, lane i) is simply {b, i} since DATA_BYTES is a power of two.
  function automatic logic [DATA_BYTES-1:0] beat_mask(
    input logic [BCW-1:0]        b,
    input logic                  we,
    input logic                  rmw,
    input logic [DATA_BYTES-1:0] wmask,
    input logic [OFSW-1:0]       ofs,
    input logic [LENW-1:0]       len
  );
    logic [SUMW-1:0] lo;
    logic [SUMW-1:0] hi;
    logic [SUMW-1:0] g;
    beat_mask = '0;
    lo = SUMW'(ofs);
    hi = SUMW'(ofs) + SUMW'(len);
    if (we && !rmw) begin
      if (len == '0) begin
        beat_mask = ~wmask;
      end else begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          g = SUMW'({b, OFSW'(i)});
          beat_mask[i] = !((g >= lo) && (g < hi));
        end
      end
    end
  endfunction

  function automatic logic range_ovf(input logic [OFSW-1:0] ofs, input logic [LENW-1:0] len);
    logic [SUMW-1:0] sum;
    sum = SUMW'(ofs) + SUMW'(len);
    range_ovf = (len != '0) && (sum > SUMW'(DATA_BYTES * MAX_BEATS));
  endfunction

  // Index of the final beat: ceil((ofs+len)/DATA_BYTES)-1, clamped to MAX_BEATS-1.
  function automatic logic [BCW-1:0] last_idx(input logic [OFSW-1:0] ofs, input logic [LENW-1:0] len);
    logic [SUMW-1:0] sum;
    logic [SUMW-1:0] nb;
    sum = SUMW'(ofs) + SUMW'(len);
    nb  = (sum + SUMW'(DATA_BYTES - 1)) >> OFSW;
    if (len == '0) begin
      last_idx = '0;
    end else if (nb > SUMW'(MAX_BEATS)) begin
      last_idx = BCW'(MAX_BEATS - 1);
    end else begin
      last_idx = BCW'(nb - SUMW'(1));
    end
  endfunction

  always_comb begin
    beat_d     = beat_q + BCW'(1);
    mask_nxt_d = beat_mask(beat_d, we_q, rmw_q, wmask_q, offset_q, len_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      rmw_q        <= 1'b0;
      wmask_q      <= '0;
      offset_q     <= '0;
      len_q        <= '0;
      last_q       <= '0;
      beat_q       <= '0;
      mask2_q      <= '0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      mask_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            rmw_q    <= req_rmw;
            wmask_q  <= req_wmask;
            offset_q <= req_offset;
            len_q    <= req_len;
            // Raised here so the pulse occupies exactly the CALC cycle.
            err_q    <= range_ovf(req_offset, req_len);
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          mask2_q <= beat_mask('0, we_q, rmw_q, wmask_q, offset_q, len_q);
          last_q  <= last_idx(offset_q, len_q);
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          mask_q       <= mask2_q;
          mask_valid_q <= 1'b1;
          mask_last_q  <= (last_q == '0);
          beat_q       <= '0;
          state_q      <= S_BURST;
        end
        S_BURST: begin
          if (beat_adv && mask_valid_q) begin
            if (mask_last_q) begin
              mask_q       <= '0;
              mask_valid_q <= 1'b0;
              mask_last_q  <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              beat_q      <= beat_d;
              mask_q      <= mask_nxt_d;
              mask_last_q <= (beat_d == last_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mask       = mask_q;
  assign mask_valid = mask_valid_q;
  assign mask_last  = mask_last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mpmc12_mask_gen.sv
// Scoreboard bench for mpmc12_mask_gen: directed requests push expected beats, a monitor
// pops and compares each beat the PHY consumes.
module tb_mpmc12_mask_gen;
  localparam int DB   = 32;
  localparam int MB   = 8;
  localparam int OFSW = 5;
  localparam int LENW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic            req_rmw;
  logic [DB-1:0]   req_wmask;
  logic [OFSW-1:0] req_offset;
  logic [LENW-1:0] req_len;
  logic            beat_adv;
  logic [DB-1:0]   mask;
  logic            mask_valid;
  logic            mask_last;
  logic            busy;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  mpmc12_mask_gen #(.DATA_BYTES(DB), .MAX_BEATS(MB)) dut (
    .rst(rst), .clk(clk),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_rmw(req_rmw),
    .req_wmask(req_wmask), .req_offset(req_offset), .req_len(req_len),
    .beat_adv(beat_adv), .mask(mask), .mask_valid(mask_valid), .mask_last(mask_last),
    .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] m, input logic l);
    exp_q.push_back({l, m});
  endtask

  // Monitor: every beat the PHY consumes is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && mask_valid && beat_adv) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: got mask %h, scoreboard empty", mask);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("beat_mask", mask, e[31:0]);
        chk("beat_last", 32'(mask_last), 32'(e[32]));
      end
    end
  end

  task automatic run_req(input logic we, input logic rmw, input logic [31:0] wm,
                         input logic [OFSW-1:0] ofs, input logic [LENW-1:0] len,
                         input logic exp_err);
    int n;
    n = 0;
    req_we = we; req_rmw = rmw; req_wmask = wm; req_offset = ofs; req_len = len;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_valid", 32'(mask_valid), 32'd0);
    chk("calc_err", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk("load_valid", 32'(mask_valid), 32'd0);
    chk("load_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("burst_valid", 32'(mask_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_rmw = 1'b0; req_wmask = '0;
    req_offset = '0; req_len = '0; beat_adv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mask", mask, 32'd0);
    chk("rst_valid", 32'(mask_valid), 32'd0);
    chk("rst_last", 32'(mask_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Reset in beat 2 of a 4-beat range (offset 8, len 100).
    push(32'h0000_00FF, 1'b0);
    push(32'h0000_0000, 1'b0);
    run_req(1'b1, 1'b0, 32'h0, 5'd8, 9'd100, 1'b0);
    beat_adv = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    beat_adv = 1'b0;
    chk("beat2_valid", 32'(mask_valid), 32'd1);
    chk("beat2_last", 32'(mask_last), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_mask", mask, 32'd0);
    chk("arst_valid", 32'(mask_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(mask_last), 32'd0);
    chk("arst_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Explicit single-beat mask.
    push(32'hFFFF_0000, 1'b1);
    beat_adv = 1'b1;
    run_req(1'b1, 1'b0, 32'h0000_FFFF, 5'd0, 9'd0, 1'b0);
    chk("expl_mask", mask, 32'hFFFF_0000);
    chk("expl_last", 32'(mask_last), 32'd1);
    wait_idle();
    chk("expl_post_mask", mask, 32'd0);
    chk("expl_post_valid", 32'(mask_valid), 32'd0);

    // Range offset 4 len 60: two beats, no bubble under continuous beat_adv.
    push(32'h0000_000F, 1'b0);
    push(32'h0000_0000, 1'b1);
    run_req(1'b1, 1'b0, 32'h0, 5'd4, 9'd60, 1'b0);
    chk("rng_b0_mask", mask, 32'h0000_000F);
    chk("rng_b0_last", 32'(mask_last), 32'd0);
    @(posedge clk); #1;
    chk("rng_b1_valid", 32'(mask_valid), 32'd1);
    chk("rng_b1_mask", mask, 32'd0);
    chk("rng_b1_last", 32'(mask_last), 32'd1);
    wait_idle();

    // RMW write-back and plain read: all bytes enabled.
    push(32'h0, 1'b1);
    run_req(1'b1, 1'b1, 32'h0, 5'd3, 9'd5, 1'b0);
    wait_idle();
    push(32'h0, 1'b0);
    push(32'h0, 1'b1);
    run_req(1'b0, 1'b0, 32'h0, 5'd0, 9'd64, 1'b0);
    wait_idle();

    // Overflow: offset 16 len 256 truncates to 8 beats with an err pulse.
    push(32'h0000_FFFF, 1'b0);
    for (int b = 1; b < 7; b++) push(32'h0, 1'b0);
    push(32'h0, 1'b1);
    run_req(1'b1, 1'b0, 32'h0, 5'd16, 9'd256, 1'b1);
    wait_idle();

    // beat_adv held through LOAD, second request raised during the burst.
    push(32'h0000_000F, 1'b0);
    push(32'h0000_0000, 1'b1);
    push(32'hFFFF_FF00, 1'b1);
    run_req(1'b1, 1'b0, 32'h0, 5'd4, 9'd60, 1'b0);
    req_we = 1'b1; req_rmw = 1'b0; req_wmask = 32'h0000_00FF; req_offset = '0; req_len = '0;
    req_valid = 1'b1;
    chk("ovl_ready_b0", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("ovl_ready_b1", 32'(req_ready), 32'd0);
    chk("ovl_busy_b1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("ovl_idle_busy", 32'(busy), 32'd0);
    chk("ovl_idle_ready", 32'(req_ready), 32'd1);
    chk("ovl_idle_valid", 32'(mask_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ovl_accept", 32'(busy), 32'd1);
    wait_idle();
    beat_adv = 1'b0;
    @(posedge clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mpmc12_mask_gen.md
Name: mpmc12_mask_gen

Overview:
- Parametrised per-beat write data-mask generator for the multi-port memory controller data path.
- Accepts one write or read request: either an explicit single-beat byte-enable mask, or a byte range (start offset + length) spanning up to MAX_BEATS beats.
- Emits one DDR data mask per beat, stepped by the PHY's beat-advance strobe. Mask bit = 1 means the byte is not written.
- RMW and read requests produce all-zero masks (every byte enabled).

Parameters:
- DATA_BYTES, 32, bytes per beat; power of two, ≥ 4.
- MAX_BEATS, 8, maximum beats per request; power of two, ≥ 1.
- OFSW, $clog2(DATA_BYTES), offset width; derived, not overridden.
- LENW, $clog2(DATA_BYTES*MAX_BEATS)+1, length width; derived, not overridden.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_rmw  in  1  read-modify-write write-back; all bytes written
- req_wmask  in  DATA_BYTES  byte enables (1 = write), used only when req_len == 0
- req_offset  in  OFSW  starting byte within beat 0
- req_len  in  LENW  byte count; 0 selects explicit-mask single-beat mode
- beat_adv  in  1  PHY consumed current mask
- mask  out  DATA_BYTES  current beat mask, 1 = masked
- mask_valid  out  1  mask is valid for the current beat
- mask_last  out  1  current beat is the final beat
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse: range truncated

Behaviour:
- Reset (async, any state): state = IDLE; mask = 0; mask_valid = 0; mask_last = 0; err = 0; beat counter = 0; latched request fields = 0.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, latch we / rmw / wmask / offset / len and go to CALC.
  - CALC: compute nbeats and the beat-0 mask into a staging register (mask2); go to LOAD.
  - LOAD: mask <= mask2, mask_valid <= 1, beat = 0; go to BURST.
  - BURST: on beat_adv && mask_valid:
    - if mask_last: mask <= 0, mask_valid <= 0, mask_last <= 0, next state IDLE;
    - else beat++ and mask <= mask for beat+1, computed combinationally from the latched fields; no bubble between beats.
- Latency: request accepted at edge N; mask_valid rises at edge N+2; mask_valid is high on the edge after N+2 (stable from cycle N+3).
- Beat count:
  - len == 0: nbeats = 1.
  - otherwise nbeats = ceil((offset+len)/DATA_BYTES), computed at LENW+1 bits so no overflow.
  - If offset+len > DATA_BYTES*MAX_BEATS: nbeats = MAX_BEATS and err pulses for 1 cycle in CALC; bytes beyond the last beat are dropped.
- Mask for beat b, byte i, with g = b*DATA_BYTES + i:
  - write, !rmw, len != 0: mask[i] = !(offset ≤ g < offset+len).
  - write, !rmw, len == 0: mask = ~wmask.
  - rmw = 1 (any we) or we = 0: mask = 0 for every beat.
- mask_last = (beat == nbeats-1) while mask_valid.
- beat_adv while mask_valid == 0 is ignored.
- req_valid while not IDLE is ignored; req_ready = 0 there, and the request is not latched.
- Request arriving on the same cycle as the final beat_adv: not accepted that cycle (req_ready is still 0); accepted on the following cycle in IDLE.
- Reset asserted mid-burst: outputs clear immediately (asynchronous). No partial mask is presented after reset deasserts.
- mask holds its value between beat_adv strobes; it changes only on the edges described above.

Test Plan:
- Reset mid-BURST (beat 2 of 4) -> mask = 0, mask_valid = 0, busy = 0 asynchronously; the next request behaves normally.
- Explicit mask: len = 0, we = 1, wmask = 32'h0000_FFFF -> 1 beat, mask = 32'hFFFF_0000, mask_last = 1 at cycle N+2; after beat_adv, IDLE with mask = 0.
- Range: offset = 4, len = 60, DATA_BYTES = 32 -> 2 beats: beat0 mask = 32'h0000_000F, beat1 mask = 0, mask_last only on beat1; back-to-back beat_adv gives no bubble.
- RMW: rmw = 1, offset = 3, len = 5 -> 1 beat with mask = 0; read we = 0, len = 64 -> 2 beats, both mask = 0.
- Overflow: MAX_BEATS = 8, offset = 16, len = 256 -> nbeats = 8, err pulses once in CALC, beat0 mask = 32'h0000_FFFF, beats 1–7 mask = 0.
- beat_adv held high across LOAD plus a new req_valid during BURST -> exactly nbeats beats emitted, and the second request is not accepted until IDLE.
